// File: rtl/dds_key_ctrl.sv
// DDS front-panel key controller: turns debounced key pulses into
// waveform/frequency config updates offered over valid/ready.
module dds_key_ctrl #(
  parameter int              FW_W    = 32,
  parameter logic [FW_W-1:0] FW_INIT = 32'd85_899,
  parameter logic [FW_W-1:0] FW_MIN  = 32'd859,
  parameter logic [FW_W-1:0] FW_MAX  = 32'd858_993_459,
  parameter logic [FW_W-1:0] STEP0   = 32'd859,
  parameter logic [FW_W-1:0] STEP1   = 32'd8_590,
  parameter logic [FW_W-1:0] STEP2   = 32'd85_899,
  parameter logic [FW_W-1:0] STEP3   = 32'd858_993
) (
  input  logic            sys_clock,
  input  logic            sys_rst,
  input  logic [3:0]      key_flag,
  input  logic            cfg_ready,
  output logic            cfg_valid,
  output logic [1:0]      cfg_wave,
  output logic [FW_W-1:0] cfg_freq,
  output logic [1:0]      step_idx,
  output logic            busy,
  output logic            key_drop
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_IDLE,
    S_SEND
  } state_t;

  state_t          state_q;
  logic [3:0]      pend_q, pend_d;
  logic [3:0]      grant;
  logic            drop_q, drop_d;
  logic            valid_q;
  logic [1:0]      wave_q;
  logic [1:0]      step_q;
  logic [FW_W-1:0] freq_q;
  logic [FW_W-1:0] step_v;
  logic [FW_W:0]   sum;
  logic [FW_W:0]   lim;
  logic [FW_W-1:0] up_v;
  logic [FW_W-1:0] dn_v;

  always_comb begin
    grant = 4'b0;
    // lowest set pending bit wins
    if (state_q == S_IDLE)
      grant = pend_q & (~pend_q + 4'd1);
    pend_d = (pend_q & ~grant) | key_flag;
    drop_d = |(key_flag & pend_q & ~grant);
    step_v = STEP0;
    unique case (step_q)
      2'd0: step_v = STEP0;
      2'd1: step_v = STEP1;
      2'd2: step_v = STEP2;
      2'd3: step_v = STEP3;
      default: step_v = STEP0;
    endcase
    sum  = {1'b0, freq_q} + {1'b0, step_v};
    lim  = {1'b0, FW_MIN} + {1'b0, step_v};
    up_v = (sum > {1'b0, FW_MAX}) ? FW_MAX
                                  : sum[FW_W-1:0];
    dn_v = ({1'b0, freq_q} < lim) ? FW_MIN
                                  : freq_q - step_v;
  end

  always_ff @(posedge sys_clock) begin
    if (sys_rst) begin
      state_q <= S_BOOT;
      pend_q  <= 4'b0;
      drop_q  <= 1'b0;
      valid_q <= 1'b0;
      wave_q  <= 2'd0;
      step_q  <= 2'd0;
      freq_q  <= FW_INIT;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
      unique case (state_q)
        S_BOOT: begin
          state_q <= S_SEND;
          valid_q <= 1'b1;
        end
        S_IDLE: begin
          unique case (1'b1)
            grant[0]: begin
              wave_q  <= wave_q + 2'd1;
              valid_q <= 1'b1;
              state_q <= S_SEND;
            end
            grant[1]: begin
              freq_q  <= up_v;
              valid_q <= 1'b1;
              state_q <= S_SEND;
            end
            grant[2]: begin
              freq_q  <= dn_v;
              valid_q <= 1'b1;
              state_q <= S_SEND;
            end
            grant[3]: step_q <= step_q + 2'd1;
            default: ;
          endcase
        end
        S_SEND: begin
          if (cfg_ready) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_BOOT;
      endcase
    end
  end

  assign cfg_valid = valid_q;
  assign cfg_wave  = wave_q;
  assign cfg_freq  = freq_q;
  assign step_idx  = step_q;
  assign key_drop  = drop_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dds_key_ctrl.sv
// Random-stimulus bench for dds_key_ctrl against a
// transaction-level reference model.
module tb_dds_key_ctrl;

  localparam longint FW_INIT = 85_899;
  localparam longint FW_MIN  = 859;
  localparam longint FW_MAX  = 858_993_459;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  kf;
  logic        rdy;
  logic        cfg_valid;
  logic [1:0]  cfg_wave;
  logic [31:0] cfg_freq;
  logic [1:0]  step_idx;
  logic        busy;
  logic        key_drop;

  int nvec = 0;
  int nerr = 0;

  longint steps [4] = '{859, 8_590, 85_899, 858_993};

  // reference model state
  bit     m_boot;
  bit     m_valid;
  bit     m_drop;
  int     m_wave;
  int     m_step;
  longint m_freq;
  bit     m_pend [4];

  always #5 clk = ~clk;

  dds_key_ctrl dut (
    .sys_clock (clk),
    .sys_rst   (rst),
    .key_flag  (kf),
    .cfg_ready (rdy),
    .cfg_valid (cfg_valid),
    .cfg_wave  (cfg_wave),
    .cfg_freq  (cfg_freq),
    .step_idx  (step_idx),
    .busy      (busy),
    .key_drop  (key_drop)
  );

  task automatic chk(input string tag,
                     input longint obs,
                     input longint exp);
    nvec++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit r,
                            input logic [3:0] k,
                            input bit rd);
    int g;
    if (r) begin
      m_boot = 1; m_valid = 0; m_drop = 0;
      m_wave = 0; m_step = 0; m_freq = FW_INIT;
      for (int i = 0; i < 4; i++) m_pend[i] = 0;
      return;
    end
    g = -1;
    if (m_boot) begin
      m_boot = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (rd) m_valid = 0;
    end else begin
      for (int i = 3; i >= 0; i--)
        if (m_pend[i]) g = i;
      case (g)
        0: begin m_wave = (m_wave + 1) % 4; m_valid = 1; end
        1: begin
          m_freq = m_freq + steps[m_step];
          if (m_freq > FW_MAX) m_freq = FW_MAX;
          m_valid = 1;
        end
        2: begin
          if (m_freq < FW_MIN + steps[m_step]) m_freq = FW_MIN;
          else m_freq = m_freq - steps[m_step];
          m_valid = 1;
        end
        3: m_step = (m_step + 1) % 4;
        default: ;
      endcase
    end
    m_drop = 0;
    for (int i = 0; i < 4; i++)
      if (k[i] && m_pend[i] && i != g) m_drop = 1;
    if (g >= 0) m_pend[g] = 0;
    for (int i = 0; i < 4; i++)
      if (k[i]) m_pend[i] = 1;
  endtask

  task automatic check_all();
    chk("valid", cfg_valid, m_valid);
    chk("busy", busy, m_boot || m_valid);
    chk("wave", cfg_wave, m_wave);
    chk("freq", cfg_freq, m_freq);
    chk("step", step_idx, m_step);
    chk("drop", key_drop, m_drop);
  endtask

  // drive at negedge, model on posedge, check at next negedge
  task automatic cyc(input bit r,
                     input logic [3:0] k,
                     input bit rd);
    rst = r; kf = k; rdy = rd;
    @(posedge clk);
    model_step(r, k, rd);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; kf = 4'b0; rdy = 1'b0;
    @(negedge clk);
    cyc(1, 4'b0, 0);
    cyc(1, 4'b0, 1);
    chk("rst_valid", cfg_valid, 0);
    chk("rst_busy", busy, 1);
    chk("rst_freq", cfg_freq, FW_INIT);
    cyc(0, 4'b0, 1);
    chk("boot_beat", cfg_valid, 1);
    chk("boot_freq", cfg_freq, FW_INIT);
    cyc(0, 4'b0, 1);
    chk("boot_done", cfg_valid, 0);
    // all three config keys at once, then a stalled SEND
    cyc(0, 4'b0111, 1);
    for (int i = 0; i < 8; i++) cyc(0, 4'b0, 1);
    chk("multi_wave", cfg_wave, 1);
    cyc(0, 4'b0001, 0);
    for (int i = 0; i < 20; i++)
      cyc(0, (i == 3 || i == 9) ? 4'b0001 : 4'b0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 4'b0, 1);
    chk("stall_wave", cfg_wave, 3);
    // general random traffic with occasional resets
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 500) == 0,
          ($urandom % 4 == 0) ? 4'($urandom) : 4'b0,
          ($urandom % 3) != 0);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0, 1);
    for (int n = 0; n < 200 && m_step != 3; n++)
      cyc(0, ($urandom % 2) ? 4'b1000 : 4'b0, 1);
    chk("step3", step_idx, 3);
    for (int i = 0; i < 5000; i++)
      cyc(0, ($urandom % 2) ? 4'b0010 : 4'b0,
          ($urandom % 8) != 0);
    for (int i = 0; i < 6; i++) cyc(0, 4'b0, 1);
    chk("sat_hi", cfg_freq, FW_MAX);
    for (int i = 0; i < 5000; i++)
      cyc(0, ($urandom % 2) ? 4'b0100 : 4'b0,
          ($urandom % 8) != 0);
    for (int i = 0; i < 6; i++) cyc(0, 4'b0, 1);
    chk("sat_lo", cfg_freq, FW_MIN);
    cyc(0, 4'b1000, 1);
    for (int i = 0; i < 200; i++)
      cyc(0, ($urandom % 3 == 0) ? 4'b0100 : 4'b0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 4'b0, 1);
    chk("sat_lo0", cfg_freq, FW_MIN);
    for (int i = 0; i < 2000; i++)
      cyc(($urandom % 300) == 0,
          ($urandom % 3 == 0) ? 4'($urandom) : 4'b0,
          ($urandom % 2) != 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
